// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and byte-strobe merge.
package axi_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    // Merge new_data into old_data one byte lane at a time; a cleared strobe keeps the old byte.
    function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
        input logic [AXI_DATA_W-1:0] old_data,
        input logic [AXI_DATA_W-1:0] new_data,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_data;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Combinational address decoder: maps a bus address onto a register index and
// flags accesses that fall outside the file or hit a read-only register.
module axi_lite_reg_decode
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          WINDOW_BITS = 12,
    parameter logic [63:0] RO_MASK     = 64'h0000_0000_0000_0080,
    localparam int         IDX_W       = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  wr_err,
    output logic                  rd_err
);

    // Word index inside the decoded window; byte offset bits and bits above the window are ignored.
    logic [WINDOW_BITS-3:0] win_idx;
    logic                   in_range;
    logic                   read_only;
    logic                   unused_addr_bits;

    assign win_idx  = addr[WINDOW_BITS-1:2];
    assign in_range = (32'(win_idx) < 32'(NUM_REGS));
    assign idx      = win_idx[IDX_W-1:0];

    // Look up the read-only flag for the addressed register.
    always_comb begin
        read_only = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                read_only = RO_MASK[i];
            end
        end
    end

    assign rd_err = !in_range;
    assign wr_err = !in_range || read_only;

    // Address bits outside the window are deliberately not decoded.
    assign unused_addr_bits = ^addr;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register file slave: NUM_REGS 32-bit registers, read/write ones driven
// out on reg_out, read-only ones returning hw_status; bad accesses answer SLVERR.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          WINDOW_BITS = 12,
    parameter logic [63:0] RO_MASK     = 64'h0000_0000_0000_0080,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [AXI_DATA_W-1:0]    s_wdata,
    input  logic [AXI_STRB_W-1:0]    s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [AXI_DATA_W-1:0]    s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    input  logic [NUM_REGS*32-1:0]   hw_status
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Write channel holding registers: AW and W are captured independently.
    logic                  aw_hold_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic                  w_hold_reg;
    logic [31:0]           w_data_reg;
    logic [3:0]            w_strb_reg;

    // Response channel state.
    logic                  bvalid_reg;
    axi_resp_t             bresp_reg;
    logic                  rvalid_reg;
    axi_resp_t             rresp_reg;
    logic [31:0]           rdata_reg;

    // Decode results and handshake strobes.
    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_wr_err;
    logic                  aw_rd_err;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_wr_err;
    logic                  ar_rd_err;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic [31:0]           rd_value;
    logic                  unused_inputs;

    // The held write address is decoded at commit time; the read address is decoded live.
    axi_lite_reg_decode #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WINDOW_BITS (WINDOW_BITS),
        .RO_MASK     (RO_MASK)
    ) u_aw_decode (
        .addr   (aw_addr_reg),
        .idx    (aw_idx),
        .wr_err (aw_wr_err),
        .rd_err (aw_rd_err)
    );

    axi_lite_reg_decode #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WINDOW_BITS (WINDOW_BITS),
        .RO_MASK     (RO_MASK)
    ) u_ar_decode (
        .addr   (s_araddr),
        .idx    (ar_idx),
        .wr_err (ar_wr_err),
        .rd_err (ar_rd_err)
    );

    // Ready is withheld during reset and while a write response is pending,
    // which limits the slave to a single outstanding write.
    assign s_awready = !aw_hold_reg && !bvalid_reg && !areset;
    assign s_wready  = !w_hold_reg  && !bvalid_reg && !areset;
    assign s_arready = !rvalid_reg  && !areset;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid  && s_wready;
    assign ar_fire = s_arvalid && s_arready;
    assign commit  = aw_hold_reg && w_hold_reg;

    assign s_bvalid = bvalid_reg;
    assign s_bresp  = bresp_reg;
    assign s_rvalid = rvalid_reg;
    assign s_rresp  = rresp_reg;
    assign s_rdata  = rdata_reg;

    // Per-register storage: read/write registers get a flop and a write pulse,
    // read-only slots expose a constant on reg_out since their data lives in hw_status.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (RO_MASK[gi]) begin : g_ro
                assign reg_out[gi*32 +: 32] = RESET_VAL;
                assign reg_wr_pulse[gi]     = 1'b0;
            end else begin : g_rw
                logic [31:0] value_reg;
                logic        pulse_reg;
                logic        wr_hit;

                assign wr_hit = commit && !aw_wr_err && (aw_idx == IDX_W'(gi));

                // Byte-merge the held write data on commit and flag the write for one cycle.
                always_ff @(posedge aclk) begin
                    if (areset) begin
                        value_reg <= RESET_VAL;
                        pulse_reg <= 1'b0;
                    end else begin
                        pulse_reg <= wr_hit;
                        if (wr_hit) begin
                            value_reg <= apply_wstrb(value_reg, w_data_reg, w_strb_reg);
                        end
                    end
                end

                assign reg_out[gi*32 +: 32] = value_reg;
                assign reg_wr_pulse[gi]     = pulse_reg;
            end
        end
    endgenerate

    // Read data source: stored value for read/write registers, live status for read-only ones.
    always_comb begin
        rd_value = '0;
        if (!ar_rd_err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rd_value = RO_MASK[i] ? hw_status[i*32 +: 32] : reg_out[i*32 +: 32];
                end
            end
        end
    end

    // Write channel: capture AW/W independently, commit once both are held, then hold B until accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_hold_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_hold_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= OKAY;
        end else begin
            if (aw_fire) begin
                aw_hold_reg <= 1'b1;
                aw_addr_reg <= s_awaddr;
            end
            if (w_fire) begin
                w_hold_reg <= 1'b1;
                w_data_reg <= s_wdata;
                w_strb_reg <= s_wstrb;
            end
            if (commit) begin
                aw_hold_reg <= 1'b0;
                w_hold_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= aw_wr_err ? SLVERR : OKAY;
            end else if (bvalid_reg && s_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read channel: register data and response on the AR handshake and hold them until R is accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= OKAY;
            rdata_reg  <= '0;
        end else begin
            if (ar_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_value;
                rresp_reg  <= ar_rd_err ? SLVERR : OKAY;
            end else if (rvalid_reg && s_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // Protection bits and the cross-direction error flags carry no meaning for this slave.
    assign unused_inputs = ^{s_awprot, s_arprot, aw_rd_err, ar_wr_err, hw_status};

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Bench for axi_lite_regfile_slave: directed scenarios plus random traffic, checked by
// scoreboard monitors against an array-based register model.
module tb_axi_lite_regfile_slave;
    import axi_lite_pkg::*;

    localparam int          NUM_REGS  = 8;
    localparam int          AW        = 32;
    localparam int          RO_IDX    = 7;
    localparam logic [31:0] RESET_VAL = 32'h0000_0000;
    localparam int          TIMEOUT   = 50;

    logic                   aclk;
    logic                   areset;
    logic [AW-1:0]          s_awaddr;
    logic [2:0]             s_awprot;
    logic                   s_awvalid;
    logic                   s_awready;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic                   s_wvalid;
    logic                   s_wready;
    logic [1:0]             s_bresp;
    logic                   s_bvalid;
    logic                   s_bready;
    logic [AW-1:0]          s_araddr;
    logic [2:0]             s_arprot;
    logic                   s_arvalid;
    logic                   s_arready;
    logic [31:0]            s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rvalid;
    logic                   s_rready;
    logic [NUM_REGS*32-1:0] reg_out;
    logic [NUM_REGS-1:0]    reg_wr_pulse;
    logic [NUM_REGS*32-1:0] hw_status;

    axi_lite_regfile_slave #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_WIDTH  (AW),
        .WINDOW_BITS (12),
        .RO_MASK     (64'h0000_0000_0000_0080),
        .RESET_VAL   (RESET_VAL)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_awaddr     (s_awaddr),
        .s_awprot     (s_awprot),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arprot     (s_arprot),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .hw_status    (hw_status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
    typedef struct { int idx; logic [31:0] val; } pulse_exp_t;

    logic [1:0]  exp_b_q[$];
    rd_exp_t     exp_r_q[$];
    pulse_exp_t  exp_p_q[$];
    logic [31:0] model[NUM_REGS];
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  mon_b;
    rd_exp_t     mon_r;
    pulse_exp_t  mon_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_val);
        end
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no handshake in %0d cycles, required one", what, TIMEOUT);
    endtask

    // ---------------- reference model ----------------
    function automatic int idx_of(input logic [31:0] addr);
        return int'(addr[11:2]);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int i;
        logic [31:0] mask;
        pulse_exp_t p;
        i = idx_of(addr);
        if (i >= NUM_REGS || i == RO_IDX) begin
            exp_b_q.push_back(2'b10);
        end else begin
            exp_b_q.push_back(2'b00);
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            model[i] = (model[i] & ~mask) | (data & mask);
            p.idx = i;
            p.val = model[i];
            exp_p_q.push_back(p);
        end
    endtask

    task automatic push_read(input logic [31:0] addr);
        int i;
        rd_exp_t e;
        i = idx_of(addr);
        if (i >= NUM_REGS) begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end else if (i == RO_IDX) begin
            e.data = hw_status[i*32 +: 32];
            e.resp = 2'b00;
        end else begin
            e.data = model[i];
            e.resp = 2'b00;
        end
        exp_r_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
    endtask

    // ---------------- monitors ----------------
    always @(negedge aclk) begin
        if (!areset && s_bvalid && s_bready) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b: got bresp=%0d, required no response", s_bresp);
            end else begin
                mon_b = exp_b_q.pop_front();
                check("bresp", 64'(s_bresp), 64'(mon_b));
                $display("B   bresp=%0d", s_bresp);
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && s_rvalid && s_rready) begin
            if (exp_r_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r: got rdata=%h, required no response", s_rdata);
            end else begin
                mon_r = exp_r_q.pop_front();
                check("rdata", 64'(s_rdata), 64'(mon_r.data));
                check("rresp", 64'(s_rresp), 64'(mon_r.resp));
                $display("R   rdata=%h rresp=%0d", s_rdata, s_rresp);
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && reg_wr_pulse != '0) begin
            if (exp_p_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got reg_wr_pulse=%b, required 0", reg_wr_pulse);
            end else begin
                mon_p = exp_p_q.pop_front();
                check("pulse", 64'(reg_wr_pulse), 64'(NUM_REGS'(1) << mon_p.idx));
                check("reg_out", 64'(reg_out[mon_p.idx*32 +: 32]), 64'(mon_p.val));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [31:0] addr, input int delay);
        logic hs;
        repeat (delay) begin @(posedge aclk); #1; end
        s_awaddr  = addr;
        s_awvalid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge aclk); hs = s_awready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n >= TIMEOUT) begin timeout_fail("aw"); break; end
        end
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
        logic hs;
        repeat (delay) begin @(posedge aclk); #1; end
        s_wdata  = data;
        s_wstrb  = strb;
        s_wvalid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge aclk); hs = s_wready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n >= TIMEOUT) begin timeout_fail("w"); break; end
        end
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        logic hs;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge aclk); hs = s_arready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n >= TIMEOUT) begin timeout_fail("ar"); break; end
        end
        s_arvalid = 1'b0;
    endtask

    task automatic wait_b();
        logic hs;
        for (int n = 0; ; n++) begin
            @(negedge aclk); hs = s_bvalid && s_bready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n >= TIMEOUT) begin timeout_fail("b"); break; end
        end
    endtask

    task automatic wait_r();
        logic hs;
        for (int n = 0; ; n++) begin
            @(negedge aclk); hs = s_rvalid && s_rready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n >= TIMEOUT) begin timeout_fail("r"); break; end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int da, input int dw);
        model_write(addr, data, strb);
        fork
            send_aw(addr, da);
            send_w(data, strb, dw);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        push_read(addr);
        if (stall > 0) s_rready = 1'b0;
        send_ar(addr);
        repeat (stall) begin @(posedge aclk); #1; end
        s_rready = 1'b1;
        wait_r();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] old_val;
        logic [31:0] addr;
        logic        seen;
        int          idx;

        areset = 1'b1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b1;
        s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        hw_status = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 64'(s_awready), 64'(0));
        check("rst_wready", 64'(s_wready), 64'(0));
        check("rst_arready", 64'(s_arready), 64'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_bvalid", 64'(s_bvalid), 64'(0));
        check("rst_rvalid", 64'(s_rvalid), 64'(0));
        check("rst_rdata", 64'(s_rdata), 64'(0));
        check("rst_pulse", 64'(reg_wr_pulse), 64'(0));
        for (int i = 0; i < NUM_REGS; i++)
            if (i != RO_IDX) check("rst_reg", 64'(reg_out[i*32 +: 32]), 64'(RESET_VAL));
        @(posedge aclk); #1;

        // Basic write and read-back through an address with high bits set
        do_write(32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("reg1_value", 64'(reg_out[1*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
        do_read(32'h4000_0004, 0);

        // W three cycles ahead of AW, partial strobe
        do_write(32'h0000_0008, 32'hAAAA_AAAA, 4'hF, 0, 0);
        model_write(32'h0000_0008, 32'h1122_3344, 4'b0101);
        send_w(32'h1122_3344, 4'b0101, 0);
        repeat (2) begin @(posedge aclk); #1; end
        send_aw(32'h0000_0008, 0);
        @(negedge aclk);
        check("b_lat_early", 64'(s_bvalid), 64'(0));
        @(posedge aclk); #1;
        check("b_lat", 64'(s_bvalid), 64'(1));
        wait_b();
        check("reg2_value", 64'(reg_out[2*32 +: 32]), 64'h0000_0000_AA22_AA44);

        // Read-only write, status read, out-of-range read
        do_write(32'h0000_001C, 32'h1234_5678, 4'hF, 0, 0);
        hw_status[RO_IDX*32 +: 32] = 32'h0000_CAFE;
        do_read(32'h0000_001C, 0);
        do_read(32'h0000_0040, 0);

        // B stalled for five cycles while reads proceed
        s_bready = 1'b0;
        fork
            begin
                model_write(32'h0000_0010, 32'h0F0F_1234, 4'hF);
                fork
                    send_aw(32'h0000_0010, 0);
                    send_w(32'h0F0F_1234, 4'hF, 1);
                join
                seen = 1'b0;
                for (int n = 0; n < TIMEOUT; n++) begin
                    @(negedge aclk);
                    if (s_bvalid) begin seen = 1'b1; break; end
                end
                if (!seen) timeout_fail("b_stall");
                for (int k = 0; k < 5; k++) begin
                    @(negedge aclk);
                    check("stall_awready", 64'(s_awready), 64'(0));
                    check("stall_wready", 64'(s_wready), 64'(0));
                    check("stall_bvalid", 64'(s_bvalid), 64'(1));
                    check("stall_bresp", 64'(s_bresp), 64'(0));
                    @(posedge aclk); #1;
                end
                s_bready = 1'b1;
                wait_b();
            end
            begin
                do_read(32'h0000_0008, 0);
                do_read(32'h0000_0008, 1);
            end
        join

        // Write commit and read handshake on the same register in the same cycle
        old_val = model[3];
        model_write(32'h0000_000C, 32'h5555_5555, 4'hF);
        fork
            send_aw(32'h0000_000C, 0);
            send_w(32'h5555_5555, 4'hF, 0);
        join
        exp_r_q.push_back('{data: old_val, resp: 2'b00});
        send_ar(32'h0000_000C);
        fork
            wait_r();
            wait_b();
        join
        do_read(32'h0000_000C, 0);

        // Reset between AW and W
        send_aw(32'h0000_0014, 0);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_wready", 64'(s_wready), 64'(0));
        check("mid_rst_arready", 64'(s_arready), 64'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("post_rst_bvalid", 64'(s_bvalid), 64'(0));
        end
        @(posedge aclk); #1;
        for (int i = 0; i < NUM_REGS; i++)
            if (i != RO_IDX) do_read(32'(i * 4), 0);
        do_write(32'h0000_0014, 32'h0BAD_F00D, 4'hF, 1, 0);
        do_read(32'h0000_0014, 0);

        // Random traffic
        for (int it = 0; it < 120; it++) begin
            idx = $urandom_range(0, 11);
            addr = ($urandom() & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            for (int k = 0; k < NUM_REGS; k++) hw_status[k*32 +: 32] = $urandom();
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(addr, $urandom_range(0, 2));
        end

        // Drain and final state
        repeat (3) begin @(posedge aclk); #1; end
        check("pending_b", 64'(exp_b_q.size()), 64'(0));
        check("pending_r", 64'(exp_r_q.size()), 64'(0));
        check("pending_pulse", 64'(exp_p_q.size()), 64'(0));
        for (int i = 0; i < NUM_REGS; i++)
            if (i != RO_IDX) check("final_reg", 64'(reg_out[i*32 +: 32]), 64'(model[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
